// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Types and constants shared by the ALU controller and the result
// write-back block.
//   OPCODE_W / REG_ADDR_W / DATA_W : field widths of an ALU command
//   OP_NOP                         : opcode that produces no ALU result
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int OPCODE_W   = 3;
    localparam int REG_ADDR_W = 3;
    localparam int DATA_W     = 32;

    typedef logic [OPCODE_W-1:0]   opcode_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     data_t;

    localparam opcode_t OP_NOP = 3'b111;

endpackage

// File: rtl/alu_result_writeback_if.sv
// ---------------------------------------------------------------------------
// alu_result_writeback_if
// Issue and result handshakes between the controller/ALU side and the
// write-back block.
//   issue_valid/issue_op/issue_dest -> issue_ready   (controller issues ops)
//   res_valid/res_data              -> res_ready     (ALU returns results)
// Modports:
//   master : controller/ALU side (drives valids and payloads)
//   slave  : write-back block (drives the readies)
// ---------------------------------------------------------------------------
interface alu_result_writeback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
);
    import alu_pkg::*;

    logic              issue_valid;
    opcode_t           issue_op;
    logic [ADDR_W-1:0] issue_dest;
    logic              issue_ready;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;

    modport master (
        output issue_valid, issue_op, issue_dest,
        input  issue_ready,
        output res_valid, res_data,
        input  res_ready
    );

    modport slave (
        input  issue_valid, issue_op, issue_dest,
        output issue_ready,
        input  res_valid, res_data,
        output res_ready
    );

endinterface

// File: rtl/wb_tag_fifo.sv
// ---------------------------------------------------------------------------
// wb_tag_fifo
// Small synchronous FIFO holding destination tags of in-flight ops.
//   clk, rst     : clock, synchronous active-high reset
//   push, din    : write din at the tail (ignored when full)
//   pop          : drop the head entry (ignored when empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries
//   head         : oldest entry (valid when not empty)
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ---------------------------------------------------------------------------
module wb_tag_fifo #(
    parameter  int WIDTH = 3,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Simultaneous push and pop leaves the count alone while both pointers move.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/alu_result_writeback.sv
// ---------------------------------------------------------------------------
// alu_result_writeback
// Accepts ALU results in issue order and writes each into the register file
// at the destination recorded when its op was issued.
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : issue and result handshakes
//   wr_en/addr/data : register-file write port, one cycle after result accept
//   busy            : at least one op in flight
//   pending_cnt     : number of ops in flight
//   orphan_err      : sticky, a result arrived while nothing was in flight
//   pending_mask    : per-register "write outstanding" flags, only when
//                     ALU_WB_SCOREBOARD_EN is defined
// ---------------------------------------------------------------------------
module alu_result_writeback #(
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 3,
    parameter  int TAG_DEPTH = 4,
    localparam int CNT_W     = $clog2(TAG_DEPTH + 1),
    localparam int NUM_REGS  = 2 ** ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_result_writeback_if.slave bus,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DATA_W-1:0]    wr_data,
    output logic                 busy,
    output logic [CNT_W-1:0]     pending_cnt,
    output logic                 orphan_err
`ifdef ALU_WB_SCOREBOARD_EN
    ,
    output logic [NUM_REGS-1:0]  pending_mask
`endif
);
    import alu_pkg::*;

    logic              fifo_full, fifo_empty;
    logic              push, pop;
    logic [ADDR_W-1:0] head_tag;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              orphan_err_q, orphan_err_d;

    wb_tag_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.issue_dest),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (pending_cnt),
        .head  (head_tag)
    );

    // Readies depend only on the registered count, so a full FIFO never
    // accepts an issue even if a result retires that same cycle.
    assign bus.issue_ready = !fifo_full;
    assign bus.res_ready   = !fifo_empty;
    assign busy            = !fifo_empty;

    // NOPs are accepted but never produce a result, so they get no tag.
    always_comb begin
        push = bus.issue_valid && !fifo_full && (bus.issue_op != OP_NOP);
        pop  = bus.res_valid && !fifo_empty;
    end

    always_comb begin
        wr_en_d      = pop;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        orphan_err_d = orphan_err_q || (bus.res_valid && fifo_empty);
        if (pop) begin
            wr_addr_d = head_tag;
            wr_data_d = bus.res_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            orphan_err_q <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            orphan_err_q <= orphan_err_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign orphan_err = orphan_err_q;

`ifdef ALU_WB_SCOREBOARD_EN
    // One counter per register; it can never exceed TAG_DEPTH, so CNT_W bits
    // suffice without saturation.
    logic [CNT_W-1:0] reg_cnt_q [NUM_REGS];
    logic [CNT_W-1:0] reg_cnt_d [NUM_REGS];

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_cnt_d[i] = reg_cnt_q[i];
            if ((push && bus.issue_dest == ADDR_W'(i)) && !(pop && head_tag == ADDR_W'(i)))
                reg_cnt_d[i] = reg_cnt_q[i] + CNT_W'(1);
            else if ((pop && head_tag == ADDR_W'(i)) && !(push && bus.issue_dest == ADDR_W'(i)))
                reg_cnt_d[i] = reg_cnt_q[i] - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) reg_cnt_q[i] <= '0;
            else     reg_cnt_q[i] <= reg_cnt_d[i];
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pending_mask[i] = (reg_cnt_q[i] != '0);
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// Testbench for alu_result_writeback: directed vectors, a queue-based model of
// in-flight tags checked every cycle, and literal expectations pinning the model.
module tb_alu_result_writeback;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic [2:0]  pending_cnt;
    logic        orphan_err;
`ifdef ALU_WB_SCOREBOARD_EN
    logic [7:0]  pending_mask;
`endif

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Model state
    logic [2:0]  tag_q [$];
    bit          model_live = 0;
    logic        m_wr_en;
    logic [2:0]  m_wr_addr;
    logic [31:0] m_wr_data;
    logic        m_orphan;

    alu_result_writeback_if #(.DATA_W(32), .ADDR_W(3)) bus ();

    alu_result_writeback #(
        .DATA_W    (32),
        .ADDR_W    (3),
        .TAG_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .pending_cnt  (pending_cnt),
        .orphan_err   (orphan_err)
`ifdef ALU_WB_SCOREBOARD_EN
        ,
        .pending_mask (pending_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    // Drive one cycle of inputs (called 2 time units after a rising edge),
    // then return 2 time units after the edge that samples them.
    task automatic applyStimulus(input logic r, input logic iv, input logic [2:0] op,
                                 input logic [2:0] dest, input logic rv, input logic [31:0] data);
        rst             = r;
        bus.issue_valid = iv;
        bus.issue_op    = op;
        bus.issue_dest  = dest;
        bus.res_valid   = rv;
        bus.res_data    = data;
        @(posedge clk);
        #2;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0);
    endtask

    // Behavioural model: a queue of outstanding destinations in issue order.
    always @(posedge clk) begin
        int n;
        if (rst) begin
            tag_q.delete();
            m_wr_en    = 1'b0;
            m_wr_addr  = 3'd0;
            m_wr_data  = 32'd0;
            m_orphan   = 1'b0;
            model_live = 1;
        end else begin
            n = tag_q.size();
            m_wr_en = 1'b0;
            if (bus.res_valid) begin
                if (n == 0) m_orphan = 1'b1;
                else begin
                    m_wr_en   = 1'b1;
                    m_wr_addr = tag_q.pop_front();
                    m_wr_data = bus.res_data;
                end
            end
            if (bus.issue_valid && n != DEPTH && bus.issue_op != 3'b111)
                tag_q.push_back(bus.issue_dest);
        end
    end

    // Compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (model_live) begin
`ifdef ALU_WB_SCOREBOARD_EN
            logic [7:0] exp_mask;
            exp_mask = 8'h00;
            foreach (tag_q[k]) exp_mask[tag_q[k]] = 1'b1;
            checkOutput("pending_mask", 32'(pending_mask), 32'(exp_mask));
`endif
            checkOutput("issue_ready", 32'(bus.issue_ready), 32'(tag_q.size() != DEPTH));
            checkOutput("res_ready",   32'(bus.res_ready),   32'(tag_q.size() != 0));
            checkOutput("busy",        32'(busy),            32'(tag_q.size() != 0));
            checkOutput("pending_cnt", 32'(pending_cnt),     32'(tag_q.size()));
            checkOutput("wr_en",       32'(wr_en),           32'(m_wr_en));
            checkOutput("wr_addr",     32'(wr_addr),         32'(m_wr_addr));
            checkOutput("wr_data",     wr_data,              m_wr_data);
            checkOutput("orphan_err",  32'(orphan_err),      32'(m_orphan));
        end
    end

    initial begin
        rst             = 1'b1;
        bus.issue_valid = 1'b0;
        bus.issue_op    = 3'd0;
        bus.issue_dest  = 3'd0;
        bus.res_valid   = 1'b0;
        bus.res_data    = 32'd0;
        repeat (2) @(posedge clk);
        #2;
        $display("[TB] reset and idle");
        idleCycles(1);
        checkOutput("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        checkOutput("rst_res_ready",   32'(bus.res_ready),   32'd0);
        checkOutput("rst_wr_en",       32'(wr_en),           32'd0);
        checkOutput("rst_pending",     32'(pending_cnt),     32'd0);
        checkOutput("rst_orphan",      32'(orphan_err),      32'd0);

        $display("[TB] single op");
        applyStimulus(1'b0, 1'b1, 3'b000, 3'd5, 1'b0, 32'h0);
        checkOutput("single_pending", 32'(pending_cnt), 32'd1);
        applyStimulus(1'b0, 1'b0, 3'b000, 3'd0, 1'b1, 32'h0000_00AA);
        checkOutput("single_wr_en",   32'(wr_en),       32'd1);
        checkOutput("single_wr_addr", 32'(wr_addr),     32'd5);
        checkOutput("single_wr_data", wr_data,          32'h0000_00AA);
        checkOutput("single_drain",   32'(pending_cnt), 32'd0);
        idleCycles(1);
        checkOutput("single_wr_off",  32'(wr_en),       32'd0);
        checkOutput("single_hold",    32'(wr_addr),     32'd5);

        $display("[TB] ordering and fill");
        for (int d = 1; d <= 4; d++)
            applyStimulus(1'b0, 1'b1, 3'(d), 3'(d), 1'b0, 32'h0);
        checkOutput("fill_issue_ready", 32'(bus.issue_ready), 32'd0);
        checkOutput("fill_pending",     32'(pending_cnt),     32'd4);
        // Full: issue and result together, only the pop happens.
        applyStimulus(1'b0, 1'b1, 3'b010, 3'd6, 1'b1, 32'h11);
        checkOutput("full_pop_cnt",  32'(pending_cnt), 32'd3);
        checkOutput("full_pop_addr", 32'(wr_addr),     32'd1);
        checkOutput("full_pop_data", wr_data,          32'h11);
        // Count 3: push and pop in the same cycle.
        applyStimulus(1'b0, 1'b1, 3'b011, 3'd7, 1'b1, 32'h22);
        checkOutput("pushpop_cnt",  32'(pending_cnt), 32'd3);
        checkOutput("pushpop_addr", 32'(wr_addr),     32'd2);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h33);
        checkOutput("order_addr3", 32'(wr_addr), 32'd3);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h44);
        checkOutput("order_addr4", 32'(wr_addr), 32'd4);
        checkOutput("order_data4", wr_data,      32'h44);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h77);
        checkOutput("order_addr7", 32'(wr_addr),     32'd7);
        checkOutput("order_empty", 32'(pending_cnt), 32'd0);

        $display("[TB] duplicate destination, register 0");
        applyStimulus(1'b0, 1'b1, 3'b001, 3'd0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b100, 3'd0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h1);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h2);
        checkOutput("dup_addr", 32'(wr_addr), 32'd0);
        checkOutput("dup_last", wr_data,      32'h2);

        $display("[TB] NOP and orphan");
        applyStimulus(1'b0, 1'b1, 3'b111, 3'd6, 1'b0, 32'h0);
        checkOutput("nop_pending", 32'(pending_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h99);
        checkOutput("orphan_no_wr", 32'(wr_en),      32'd0);
        checkOutput("orphan_set",   32'(orphan_err), 32'd1);
        idleCycles(3);
        checkOutput("orphan_held",  32'(orphan_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0);
        checkOutput("orphan_clear", 32'(orphan_err), 32'd0);

        $display("[TB] reset mid-flight");
        applyStimulus(1'b0, 1'b1, 3'b000, 3'd2, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b001, 3'd2, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 3'b010, 3'd7, 1'b0, 32'h0);
`ifdef ALU_WB_SCOREBOARD_EN
        checkOutput("mask_three", 32'(pending_mask), 32'h84);
`endif
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'h5A);
        checkOutput("mid_addr", 32'(wr_addr), 32'd2);
`ifdef ALU_WB_SCOREBOARD_EN
        checkOutput("mask_after_pop", 32'(pending_mask), 32'h84);
`endif
        applyStimulus(1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0);
        checkOutput("flush_cnt", 32'(pending_cnt), 32'd0);
`ifdef ALU_WB_SCOREBOARD_EN
        checkOutput("mask_flush", 32'(pending_mask), 32'h00);
`endif
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 32'hBEEF);
        checkOutput("late_orphan", 32'(orphan_err), 32'd1);
        checkOutput("late_no_wr",  32'(wr_en),      32'd0);
        idleCycles(2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
